// File: rtl/bubsys_wavegen_pkg.sv
// Shared types, constants and sample scaling for the Bubble System wavetable tone generator.
package bubsys_wavegen_pkg;

    typedef enum logic [1:0] {
        S_CH1A = 2'd0,
        S_CH1B = 2'd1,
        S_CH2A = 2'd2,
        S_CH2B = 2'd3
    } seq_state_t;

    localparam logic [11:0]       PITCH_MAX   = 12'hFFF;
    localparam int unsigned       WAVE_LEN    = 32'd32;
    localparam int unsigned       POS_W       = $clog2(WAVE_LEN);
    localparam logic signed [11:0] SAMPLE_BIAS = 12'sd8;
    localparam int unsigned       BUS_AW      = 32'd12;
    localparam int unsigned       BUS_DW      = 32'd8;

    // Unsigned nibble re-centred around zero, times volume; result is within -120..105.
    function automatic logic [7:0] scale_sample(input logic [3:0] i_s, input logic [3:0] i_v);
        logic signed [11:0] w_biased;
        logic signed [11:0] w_vol;
        logic signed [11:0] w_prod;
        w_biased = $signed({8'd0, i_s}) - SAMPLE_BIAS;
        w_vol    = $signed({8'd0, i_v});
        w_prod   = w_biased * w_vol;
        return w_prod[7:0];
    endfunction

endpackage

// File: rtl/bubsys_wavegen_if.sv
// Sound-bus selects and write strobe/address/data as seen by the wave generator.
interface bubsys_wavegen_if;
    import bubsys_wavegen_pkg::*;

    logic              wave1_wr;
    logic              wave2_wr;
    logic              wave1_tg;
    logic              wave2_tg;
    logic              wr_n;
    logic [BUS_AW-1:0] addr;
    logic [BUS_DW-1:0] data;

    modport master (output wave1_wr, wave2_wr, wave1_tg, wave2_tg, wr_n, addr, data);
    modport slave  (input  wave1_wr, wave2_wr, wave1_tg, wave2_tg, wr_n, addr, data);
endinterface

// File: rtl/bubsys_prom.sv
// Dual-clock byte-wide ROM image: written from the download clock, read with one-cycle latency.
module bubsys_prom #(
    parameter int unsigned AW = 32'd9,
    parameter int unsigned DW = 32'd8
) (
    input  logic          i_wr_clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_clk,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);
    localparam int unsigned DEPTH = 32'd1 << AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_q;

    // Download port write
    always_ff @(posedge i_wr_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port
    always_ff @(posedge i_rd_clk) begin
        r_q <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_q;
endmodule

// File: rtl/bubsys_wave_ch.sv
// One tone channel: bus edge detects, pitch latch/active pitch, volume, waveform select and phase counter.
module bubsys_wave_ch import bubsys_wavegen_pkg::*; (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pcen,
    input  logic              i_wr_sel,
    input  logic              i_tg_sel,
    input  logic              i_wr_n,
    input  logic [BUS_AW-1:0] i_addr,
    input  logic [BUS_DW-1:0] i_data,
    output logic [2:0]        o_wf,
    output logic [3:0]        o_vol,
    output logic [POS_W-1:0]  o_pos
);
    logic             r_wr_act;
    logic             r_tg_act;
    logic [11:0]      r_latch;
    logic [11:0]      r_pitch;
    logic [11:0]      r_cnt;
    logic [2:0]       r_wf;
    logic [3:0]       r_vol;
    logic [POS_W-1:0] r_pos;

    logic w_wr_act;
    logic w_tg_act;
    logic w_wr_edge;
    logic w_tg_edge;
    logic w_unused_bits;

    assign w_wr_act      = i_wr_sel & ~i_wr_n;
    assign w_tg_act      = i_tg_sel & ~i_wr_n;
    assign w_wr_edge     = w_wr_act & ~r_wr_act;
    assign w_tg_edge     = w_tg_act & ~r_tg_act;
    assign w_unused_bits = i_data[4];

    // Channel state; a trigger copies the latch as it was before any same-cycle write
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_act <= 1'b0;
            r_tg_act <= 1'b0;
            r_latch  <= 12'd0;
            r_pitch  <= 12'd0;
            r_cnt    <= 12'd0;
            r_wf     <= 3'd0;
            r_vol    <= 4'd0;
            r_pos    <= 5'd0;
        end else begin
            r_wr_act <= w_wr_act;
            r_tg_act <= w_tg_act;
            if (w_wr_edge) begin
                r_wf    <= i_data[7:5];
                r_vol   <= i_data[3:0];
                r_latch <= i_addr;
            end
            if (w_tg_edge) begin
                r_pitch <= r_latch;
            end
            if (i_pcen) begin
                if (r_cnt == PITCH_MAX) begin
                    r_cnt <= r_pitch;
                    r_pos <= r_pos + 5'd1;
                end else begin
                    r_cnt <= r_cnt + 12'd1;
                end
            end
        end
    end

    assign o_wf  = r_wf;
    assign o_vol = r_vol;
    assign o_pos = r_pos;
endmodule

// File: rtl/bubsys_wavegen.sv
// Dual-channel wavetable tone generator: two channels share one waveform PROM via a 4-phase sequencer.
module bubsys_wavegen import bubsys_wavegen_pkg::*; #(
    parameter int unsigned PROM_AW   = 32'd9,
    parameter int unsigned MIX_SHIFT = 32'd6
) (
    input  logic               i_EMU_MCLK,
    input  logic               i_EMU_RST,
    input  logic               i_EMU_CLK3M58_PCEN,
    bubsys_wavegen_if.slave    i_SBUS,
    input  logic               i_EMU_PROM_CLK,
    input  logic [PROM_AW-1:0] i_EMU_PROM_ADDR,
    input  logic [7:0]         i_EMU_PROM_DATA,
    input  logic               i_EMU_PROM_WR,
    input  logic               i_EMU_PROM_WAVE_CS,
    output logic [7:0]         o_CH1,
    output logic [7:0]         o_CH2,
    output logic [15:0]        o_MIX
);
    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [PROM_AW-1:0] w_prom_addr;
    logic [7:0]       w_prom_q;
    logic [2:0]       w_wf1, w_wf2;
    logic [3:0]       w_vol1, w_vol2;
    logic [POS_W-1:0] w_pos1, w_pos2;
    logic [7:0]       r_ch1, r_ch2;
    logic [15:0]      r_mix;
    logic [8:0]       w_sum9;
    logic [15:0]      w_sum16;
    logic             w_unused_bits;

    bubsys_wave_ch u_ch1 (
        .i_clk    (i_EMU_MCLK),
        .i_rst    (i_EMU_RST),
        .i_pcen   (i_EMU_CLK3M58_PCEN),
        .i_wr_sel (i_SBUS.wave1_wr),
        .i_tg_sel (i_SBUS.wave1_tg),
        .i_wr_n   (i_SBUS.wr_n),
        .i_addr   (i_SBUS.addr),
        .i_data   (i_SBUS.data),
        .o_wf     (w_wf1),
        .o_vol    (w_vol1),
        .o_pos    (w_pos1)
    );

    bubsys_wave_ch u_ch2 (
        .i_clk    (i_EMU_MCLK),
        .i_rst    (i_EMU_RST),
        .i_pcen   (i_EMU_CLK3M58_PCEN),
        .i_wr_sel (i_SBUS.wave2_wr),
        .i_tg_sel (i_SBUS.wave2_tg),
        .i_wr_n   (i_SBUS.wr_n),
        .i_addr   (i_SBUS.addr),
        .i_data   (i_SBUS.data),
        .o_wf     (w_wf2),
        .o_vol    (w_vol2),
        .o_pos    (w_pos2)
    );

    bubsys_prom #(
        .AW (PROM_AW),
        .DW (32'd8)
    ) u_prom (
        .i_wr_clk  (i_EMU_PROM_CLK),
        .i_wr_en   (i_EMU_PROM_WR & i_EMU_PROM_WAVE_CS),
        .i_wr_addr (i_EMU_PROM_ADDR),
        .i_wr_data (i_EMU_PROM_DATA),
        .i_rd_clk  (i_EMU_MCLK),
        .i_rd_addr (w_prom_addr),
        .o_rd_data (w_prom_q)
    );

    assign w_unused_bits = ^w_prom_q[7:4];
    assign w_sum9        = {r_ch1[7], r_ch1} + {r_ch2[7], r_ch2};
    assign w_sum16       = {{7{w_sum9[8]}}, w_sum9};

    // Sequencer next state and PROM address; the B phases just hold the address
    always_comb begin
        w_state_nxt = S_CH1A;
        w_prom_addr = {1'b0, w_wf1, w_pos1};
        case (r_state)
            S_CH1A: begin
                w_state_nxt = S_CH1B;
                w_prom_addr = {1'b0, w_wf1, w_pos1};
            end
            S_CH1B: begin
                w_state_nxt = S_CH2A;
                w_prom_addr = {1'b0, w_wf1, w_pos1};
            end
            S_CH2A: begin
                w_state_nxt = S_CH2B;
                w_prom_addr = {1'b1, w_wf2, w_pos2};
            end
            S_CH2B: begin
                w_state_nxt = S_CH1A;
                w_prom_addr = {1'b1, w_wf2, w_pos2};
            end
            default: begin
                w_state_nxt = S_CH1A;
                w_prom_addr = {1'b0, w_wf1, w_pos1};
            end
        endcase
    end

    // Sequencer state and registered channel/mix outputs
    always_ff @(posedge i_EMU_MCLK) begin
        if (i_EMU_RST) begin
            r_state <= S_CH1A;
            r_ch1   <= 8'd0;
            r_ch2   <= 8'd0;
            r_mix   <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_CH1B:  r_ch1 <= scale_sample(w_prom_q[3:0], w_vol1);
                S_CH2B:  r_ch2 <= scale_sample(w_prom_q[3:0], w_vol2);
                S_CH1A:  r_mix <= w_sum16 << MIX_SHIFT;
                default: r_mix <= r_mix;
            endcase
        end
    end

    assign o_CH1 = r_ch1;
    assign o_CH2 = r_ch2;
    assign o_MIX = r_mix;
endmodule
